// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: sequencer states, decode
// field constants, shifter select encodings, ARM condition codes and DP opcodes.
package proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SHIFT,
        S_EXEC,
        S_MEM,
        S_BRANCH
    } seq_state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [2:0] SEL_DP_REG  = 3'b000;
    localparam logic [2:0] SEL_DP_IMM  = 3'b001;
    localparam logic [2:0] SEL_MEM_IMM = 3'b010;
    localparam logic [2:0] SEL_MEM_REG = 3'b011;
    localparam logic [2:0] SEL_BR      = 3'b101;
    localparam logic [2:0] SEL_NONE    = 3'b111;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    localparam logic [3:0] DP_AND = 4'h0;
    localparam logic [3:0] DP_EOR = 4'h1;
    localparam logic [3:0] DP_SUB = 4'h2;
    localparam logic [3:0] DP_RSB = 4'h3;
    localparam logic [3:0] DP_ADD = 4'h4;
    localparam logic [3:0] DP_ADC = 4'h5;
    localparam logic [3:0] DP_SBC = 4'h6;
    localparam logic [3:0] DP_RSC = 4'h7;
    localparam logic [3:0] DP_TST = 4'h8;
    localparam logic [3:0] DP_TEQ = 4'h9;
    localparam logic [3:0] DP_CMP = 4'hA;
    localparam logic [3:0] DP_CMN = 4'hB;
    localparam logic [3:0] DP_ORR = 4'hC;
    localparam logic [3:0] DP_MOV = 4'hD;
    localparam logic [3:0] DP_BIC = 4'hE;
    localparam logic [3:0] DP_MVN = 4'hF;

    // Logical ops take C from the shifter and leave V alone.
    function automatic logic is_logical(input logic [3:0] opcode);
        case (opcode)
            DP_AND, DP_EOR, DP_TST, DP_TEQ,
            DP_ORR, DP_MOV, DP_BIC, DP_MVN: is_logical = 1'b1;
            default:                        is_logical = 1'b0;
        endcase
    endfunction

    // TST/TEQ/CMP/CMN only set flags and never write a register.
    function automatic logic is_compare(input logic [3:0] opcode);
        is_compare = (opcode[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the NZCV flags (combinational).
module cond_check
    import proc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch, decode, shifter wait, execute/memory/branch,
// then register-file, PC and flag writeback with registered single-cycle strobes.
module instr_sequencer
    import proc_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] IR,
    output logic [2:0]  CTRL_select,
    input  logic        was_shifted,
    input  logic        shift_carry,
    input  logic [3:0]  alu_nzcv,
    output logic [3:0]  flags,
    output logic        rf_we,
    output logic        rf_link,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        busy,
    output logic        retired,
    output logic        undef
);

    seq_state_t state;

    logic [1:0] op;
    logic [3:0] opcode;
    logic       s_bit;
    logic       l_bit;
    logic       link;

    assign op     = IR[27:26];
    assign opcode = IR[24:21];
    assign s_bit  = IR[20];
    assign l_bit  = IR[20];
    assign link   = IR[24];

    logic cond_pass;

    cond_check u_cond_check (
        .cond (IR[31:28]),
        .nzcv (flags),
        .pass (cond_pass)
    );

    logic       retire_now;
    logic [3:0] flags_next;

    always_comb begin
        retire_now = 1'b0;
        case (state)
            S_DECODE: retire_now = ~cond_pass;
            S_SHIFT:  retire_now = (op == OP_UNDEF);
            S_EXEC:   retire_now = 1'b1;
            S_MEM:    retire_now = dmem_ack;
            S_BRANCH: retire_now = 1'b1;
            default:  retire_now = 1'b0;
        endcase
    end

    always_comb begin
        flags_next = {alu_nzcv[3:2], alu_nzcv[1:0]};
        if (is_logical(opcode))
            flags_next = {alu_nzcv[3:2], (was_shifted ? shift_carry : flags[1]), flags[0]};
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            IR          <= '0;
            flags       <= '0;
            CTRL_select <= SEL_NONE;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            rf_we       <= 1'b0;
            rf_link     <= 1'b0;
            pc_we       <= 1'b0;
            pc_sel      <= 1'b0;
            retired     <= 1'b0;
            undef       <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= only; pulses default low here and a later
            // assignment in the same block overrides, giving clean one-cycle strobes.
            rf_we   <= 1'b0;
            rf_link <= 1'b0;
            pc_we   <= 1'b0;
            pc_sel  <= 1'b0;
            retired <= 1'b0;
            undef   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        IR          <= imem_rdata;
                        CTRL_select <= imem_rdata[27:25];
                        imem_req    <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (cond_pass)
                        state <= S_SHIFT;
                end
                S_SHIFT: begin
                    case (op)
                        OP_DP:  state <= S_EXEC;
                        OP_MEM: begin
                            state    <= S_MEM;
                            dmem_req <= 1'b1;
                            dmem_we  <= ~l_bit;
                        end
                        OP_BR:  state <= S_BRANCH;
                        default: undef <= 1'b1;
                    endcase
                end
                S_EXEC: begin
                    rf_we <= ~is_compare(opcode);
                    if (s_bit)
                        flags <= flags_next;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rf_we    <= l_bit;
                    end
                end
                S_BRANCH: begin
                    pc_sel  <= 1'b1;
                    rf_we   <= link;
                    rf_link <= link;
                end
                default: state <= S_IDLE;
            endcase

            // Every completion path advances the PC and returns to FETCH or IDLE.
            if (retire_now) begin
                retired     <= 1'b1;
                pc_we       <= 1'b1;
                CTRL_select <= SEL_NONE;
                state       <= run ? S_FETCH : S_IDLE;
                imem_req    <= run;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-computed expectations for fetch,
// DP/flag update, condition fail/pass, undefined, LDR wait, BL and async reset.
module tb_instr_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        RST_N = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic [31:0] IR;
    logic [2:0]  CTRL_select;
    logic        was_shifted = 1'b0;
    logic        shift_carry = 1'b0;
    logic [3:0]  alu_nzcv = 4'b0000;
    logic [3:0]  flags;
    logic        rf_we, rf_link, pc_we, pc_sel, busy, retired, undef;

    int compared   = 0;
    int mismatched = 0;

    instr_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .RST_N       (RST_N),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .IR          (IR),
        .CTRL_select (CTRL_select),
        .was_shifted (was_shifted),
        .shift_carry (shift_carry),
        .alu_nzcv    (alu_nzcv),
        .flags       (flags),
        .rf_we       (rf_we),
        .rf_link     (rf_link),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .busy        (busy),
        .retired     (retired),
        .undef       (undef)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK_50);
    endtask

    // Waits (bounded) for imem_req, holds ack off for 'delay' cycles, then acks.
    // Returns at the negedge of the DECODE cycle.
    task automatic fetch(input logic [31:0] instr, input int delay);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("fetch_req", imem_req, 1);
        repeat (delay) begin
            step();
            check("fetch_req_hold", imem_req, 1);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("fetch_req_drop", imem_req, 0);
        check("ir_latch", IR, instr);
        check("decode_busy", busy, 1);
    endtask

    initial begin
        // Reset state
        run = 1'b1;
        #1 RST_N = 1'b0;
        step();
        check("rst_ir", IR, 0);
        check("rst_flags", flags, 4'b0000);
        check("rst_ctrl", CTRL_select, 3'b111);
        check("rst_busy", busy, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_strobes", {rf_we, rf_link, pc_we, pc_sel, retired, undef, dmem_req, dmem_we}, 0);
        RST_N = 1'b1;
        step();

        // ADD r0,r1,r2 (no S): rf_we 3 cycles after ack, flags untouched
        fetch(32'hE0810002, 2);
        check("add_ctrl_decode", CTRL_select, 3'b000);
        check("add_rf_we_decode", rf_we, 0);
        step();
        check("add_ctrl_shift", CTRL_select, 3'b000);
        step();
        check("add_retired_exec", retired, 0);
        step();
        check("add_rf_we", rf_we, 1);
        check("add_retired", retired, 1);
        check("add_pc", {pc_we, pc_sel}, 2'b10);
        check("add_flags", flags, 4'b0000);
        check("add_ctrl_after", CTRL_select, 3'b111);
        check("add_refetch", imem_req, 1);

        // BEQ with Z=0: condition fails, retire 1 cycle after ack
        fetch(32'h0A000004, 0);
        check("beq_f_ctrl", CTRL_select, 3'b101);
        step();
        check("beq_f_retired", retired, 1);
        check("beq_f_pc", {pc_we, pc_sel}, 2'b10);
        check("beq_f_rf_we", rf_we, 0);
        check("beq_f_ctrl_after", CTRL_select, 3'b111);

        // MOVS with shifted carry: C from shifter, V kept
        was_shifted = 1'b1;
        shift_carry = 1'b1;
        alu_nzcv    = 4'b0100;
        fetch(32'hE1B00061, 1);
        step();
        step();
        check("movs_flags_exec", flags, 4'b0000);
        step();
        check("movs_flags", flags, 4'b0110);
        check("movs_rf_we", rf_we, 1);
        was_shifted = 1'b0;
        shift_carry = 1'b0;
        alu_nzcv    = 4'b0000;

        // BEQ with Z=1 now passes and branches
        fetch(32'h0A000004, 0);
        step();
        check("beq_p_retired_early", retired, 0);
        step();
        step();
        check("beq_p_pc", {pc_we, pc_sel}, 2'b11);
        check("beq_p_rf", {rf_we, rf_link}, 2'b00);
        check("beq_p_retired", retired, 1);

        // CMP: arithmetic flags from ALU, no register write
        was_shifted = 1'b1;
        shift_carry = 1'b0;
        alu_nzcv    = 4'b1001;
        fetch(32'hE1500001, 0);
        step();
        step();
        step();
        check("cmp_flags", flags, 4'b1001);
        check("cmp_rf_we", rf_we, 0);
        check("cmp_retired", retired, 1);
        was_shifted = 1'b0;
        alu_nzcv    = 4'b0000;

        // Undefined op 11: undef pulse out of SHIFT
        fetch(32'hEC000000, 0);
        check("und_ctrl", CTRL_select, 3'b110);
        step();
        check("und_early", undef, 0);
        step();
        check("und_pulse", undef, 1);
        check("und_retired", retired, 1);
        check("und_pc", {pc_we, pc_sel}, 2'b10);
        check("und_rf_we", rf_we, 0);
        check("und_flags", flags, 4'b1001);
        step();
        check("und_pulse_end", undef, 0);

        // LDR imm with dmem_ack held off for 4 MEM cycles
        fetch(32'hE5912000, 0);
        check("ldr_ctrl", CTRL_select, 3'b010);
        step();
        check("ldr_req_shift", dmem_req, 0);
        step();
        check("ldr_req", dmem_req, 1);
        check("ldr_we", dmem_we, 0);
        repeat (3) begin
            step();
            check("ldr_req_hold", dmem_req, 1);
            check("ldr_rf_we_wait", rf_we, 0);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("ldr_req_drop", dmem_req, 0);
        check("ldr_rf_we", rf_we, 1);
        check("ldr_retired", retired, 1);
        check("ldr_pc", {pc_we, pc_sel}, 2'b10);
        check("ldr_ctrl_after", CTRL_select, 3'b111);

        // BL with run dropped mid-instruction: completes, then IDLE
        fetch(32'hEB000010, 0);
        run = 1'b0;
        check("bl_ctrl", CTRL_select, 3'b101);
        step();
        step();
        check("bl_busy_mid", busy, 1);
        step();
        check("bl_pc", {pc_we, pc_sel}, 2'b11);
        check("bl_rf", {rf_we, rf_link}, 2'b11);
        check("bl_retired", retired, 1);
        check("bl_idle_busy", busy, 0);
        check("bl_idle_req", imem_req, 0);
        step();
        check("bl_stay_idle", busy, 0);
        check("bl_pulses_end", {rf_we, rf_link, pc_we, retired}, 0);

        // Async reset during MEM wait; stale ack afterwards ignored
        run = 1'b1;
        step();
        fetch(32'hE5912000, 0);
        step();
        step();
        check("rst_mem_req_before", dmem_req, 1);
        run = 1'b0;
        #3 RST_N = 1'b0;
        #1;
        check("rst_mem_req_async", dmem_req, 0);
        check("rst_mem_busy", busy, 0);
        check("rst_mem_ir", IR, 0);
        check("rst_mem_flags", flags, 4'b0000);
        check("rst_mem_ctrl", CTRL_select, 3'b111);
        step();
        RST_N    = 1'b1;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("stale_ack_busy", busy, 0);
        check("stale_ack_strobes", {dmem_req, rf_we, pc_we, retired}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
